// File: rtl/seven_segment_rx.sv
// Seven-segment receiver: qualifies a stable active-low pattern,
// decodes it to BCD and keeps a shift history of accepted digits.
module seven_segment_rx #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned NUM_DIGITS    = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [6:0]                  hex_in,
    input  logic                        sample_en,
    input  logic                        clr,
    output logic [3:0]                  digit,
    output logic                        digit_valid,
    output logic                        digit_err,
    output logic [4*NUM_DIGITS-1:0]     value,
    output logic [3:0]                  digit_count,
    output logic                        locked
);

    localparam int unsigned VW = 4 * NUM_DIGITS;
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [6:0]     cand_q, cand_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           accept;

    logic [3:0]     digit_q, digit_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic [VW-1:0]  value_q, value_d;
    logic [3:0]     count_q, count_d;
    logic           locked_q, locked_d;

    logic           dec_ok;
    logic [3:0]     dec_val;
    logic           is_blank;
    logic           is_cand;

    assign is_blank = (hex_in == BLANK);
    assign is_cand  = (hex_in == cand_q);

    // Pattern decoder for the current candidate (segments active-low)
    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'd0;
        unique case (cand_q)
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
            default:    dec_ok  = 1'b0;
        endcase
    end

    // FSM state, candidate and stability counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cand_q  <= BLANK;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: only qualified samples advance the tracker
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        if (sample_en) begin
            unique case (state_q)
                IDLE: begin
                    if (!is_blank) begin
                        cand_d  = hex_in;
                        cnt_d   = 4'd1;
                        state_d = TRACK;
                    end
                end
                TRACK: begin
                    if (is_cand) begin
                        cnt_d = cnt_q + 4'd1;
                        if (cnt_d == 4'(STABLE_CYCLES)) begin
                            accept  = 1'b1;
                            state_d = LOCKED;
                        end
                    end else if (is_blank) begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else begin
                        cand_d = hex_in;
                        cnt_d  = 4'd1;
                    end
                end
                LOCKED: begin
                    if (is_blank) begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end else if (!is_cand) begin
                        cand_d  = hex_in;
                        cnt_d   = 4'd1;
                        state_d = TRACK;
                    end
                end
                default: begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output next values; clr wins over history update, not over digit
    always_comb begin
        valid_d  = accept & dec_ok;
        err_d    = accept & ~dec_ok;
        digit_d  = valid_d ? dec_val : digit_q;
        value_d  = value_q;
        count_d  = count_q;
        locked_d = (state_d == LOCKED);
        if (clr) begin
            value_d = '0;
            count_d = 4'd0;
        end else if (valid_d) begin
            value_d = (value_q << 4) | VW'(dec_val);
            if (count_q != 4'(NUM_DIGITS)) begin
                count_d = count_q + 4'd1;
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q  <= 4'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            value_q  <= '0;
            count_q  <= 4'd0;
            locked_q <= 1'b0;
        end else begin
            digit_q  <= digit_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            value_q  <= value_d;
            count_q  <= count_d;
            locked_q <= locked_d;
        end
    end

    assign digit       = digit_q;
    assign digit_valid = valid_q;
    assign digit_err   = err_q;
    assign value       = value_q;
    assign digit_count = count_q;
    assign locked      = locked_q;

endmodule

// File: tb/tb_seven_segment_rx.sv
// Directed bench for seven_segment_rx with
// STABLE_CYCLES=4 and NUM_DIGITS=4.
module tb_seven_segment_rx;

    logic        clk;
    logic        rst_n;
    logic [6:0]  hex_in;
    logic        sample_en;
    logic        clr;
    logic [3:0]  digit;
    logic        digit_valid;
    logic        digit_err;
    logic [15:0] value;
    logic [3:0]  digit_count;
    logic        locked;

    int n_chk;
    int n_fail;
    int n_valid;
    int n_err;

    localparam logic [6:0] P_BLANK = 7'b1111111;
    localparam logic [6:0] P_1     = 7'b1111001;
    localparam logic [6:0] P_2     = 7'b0100100;
    localparam logic [6:0] P_3     = 7'b0110000;
    localparam logic [6:0] P_4     = 7'b0011001;
    localparam logic [6:0] P_5     = 7'b0010010;
    localparam logic [6:0] P_7     = 7'b1111000;
    localparam logic [6:0] P_8     = 7'b0000000;
    localparam logic [6:0] P_9     = 7'b0010000;
    localparam logic [6:0] P_BAD   = 7'b0001000;

    seven_segment_rx #(
        .STABLE_CYCLES (4),
        .NUM_DIGITS    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hex_in      (hex_in),
        .sample_en   (sample_en),
        .clr         (clr),
        .digit       (digit),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .value       (value),
        .digit_count (digit_count),
        .locked      (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given inputs; outputs sampled 1 ns after the edge
    task automatic step(input logic [6:0] h, input logic en,
                        input logic c);
        hex_in    = h;
        sample_en = en;
        clr       = c;
        @(posedge clk);
        #1;
        if (digit_valid) n_valid++;
        if (digit_err)   n_err++;
    endtask

    task automatic hold(input logic [6:0] h, input int n);
        for (int i = 0; i < n; i++) step(h, 1'b1, 1'b0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_digit"}, 32'(digit), 32'h0);
        chk({tag, "_dv"}, 32'(digit_valid), 32'h0);
        chk({tag, "_de"}, 32'(digit_err), 32'h0);
        chk({tag, "_value"}, 32'(value), 32'h0);
        chk({tag, "_count"}, 32'(digit_count), 32'h0);
        chk({tag, "_locked"}, 32'(locked), 32'h0);
    endtask

    initial begin
        logic [6:0] seq [5];
        n_chk = 0; n_fail = 0; n_valid = 0; n_err = 0;
        rst_n = 1'b0; hex_in = P_BLANK; sample_en = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        // blank samples keep the FSM idle
        hold(P_BLANK, 3);
        chk("blank_locked", 32'(locked), 32'h0);
        chk("blank_pulses", 32'(n_valid + n_err), 32'h0);

        // digit 2 qualifies on the 4th sample only, once
        hold(P_2, 3);
        chk("d2_early", 32'(n_valid), 32'h0);
        hold(P_2, 1);
        chk("d2_dv", 32'(digit_valid), 32'h1);
        chk("d2_digit", 32'(digit), 32'h2);
        chk("d2_value", 32'(value), 32'h0002);
        chk("d2_count", 32'(digit_count), 32'h1);
        chk("d2_locked", 32'(locked), 32'h1);
        n_valid = 0;
        hold(P_2, 10);
        chk("d2_no_repeat", 32'(n_valid), 32'h0);
        chk("d2_still_locked", 32'(locked), 32'h1);
        hold(P_BLANK, 1);
        chk("blank_unlock", 32'(locked), 32'h0);

        // 3 then 8: only 8 is accepted
        n_valid = 0;
        hold(P_3, 3);
        hold(P_8, 5);
        chk("d8_pulses", 32'(n_valid), 32'h1);
        chk("d8_digit", 32'(digit), 32'h8);
        chk("d8_value", 32'(value), 32'h0028);
        chk("d8_count", 32'(digit_count), 32'h2);
        hold(P_BLANK, 1);

        // invalid pattern with gated sampling
        n_valid = 0; n_err = 0;
        for (int i = 0; i < 8; i++) begin
            step(P_BAD, 1'(i % 2), 1'b0);
            if (i == 5) chk("err_early", 32'(n_err), 32'h0);
        end
        chk("err_pulse", 32'(digit_err), 32'h1);
        chk("err_count_pulses", 32'(n_err), 32'h1);
        chk("err_no_valid", 32'(n_valid), 32'h0);
        chk("err_value", 32'(value), 32'h0028);
        chk("err_count", 32'(digit_count), 32'h2);
        chk("err_digit", 32'(digit), 32'h8);
        hold(P_BLANK, 1);
        chk("err_pulse_gone", 32'(digit_err), 32'h0);

        // clr without sample_en
        step(P_BLANK, 1'b0, 1'b1);
        chk("clr_value", 32'(value), 32'h0);
        chk("clr_count", 32'(digit_count), 32'h0);

        // history shift and saturation
        seq[0] = P_1; seq[1] = P_9; seq[2] = P_4;
        seq[3] = P_7; seq[4] = P_5;
        n_valid = 0;
        for (int k = 0; k < 5; k++) begin
            hold(seq[k], 4);
            hold(P_BLANK, 1);
        end
        chk("hist_value", 32'(value), 32'h9475);
        chk("hist_count", 32'(digit_count), 32'h4);
        chk("hist_pulses", 32'(n_valid), 32'h5);
        chk("hist_digit", 32'(digit), 32'h5);

        // clr coincident with accept
        hold(P_3, 3);
        step(P_3, 1'b1, 1'b1);
        chk("clracc_dv", 32'(digit_valid), 32'h1);
        chk("clracc_digit", 32'(digit), 32'h3);
        chk("clracc_value", 32'(value), 32'h0);
        chk("clracc_count", 32'(digit_count), 32'h0);

        // clr during tracking leaves the counter alone
        hold(P_BLANK, 1);
        hold(P_1, 2);
        step(P_1, 1'b1, 1'b1);
        step(P_1, 1'b1, 1'b0);
        chk("clrtrk_dv", 32'(digit_valid), 32'h1);
        chk("clrtrk_value", 32'(value), 32'h0001);
        chk("clrtrk_count", 32'(digit_count), 32'h1);

        // async reset while locked
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_locked");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(P_BLANK, 2);
        chk("rst_idle_locked", 32'(locked), 32'h0);

        // async reset mid-track discards partial qualification
        n_valid = 0; n_err = 0;
        hold(P_4, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("rst_track");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(P_4, 3);
        chk("rst_partial", 32'(n_valid + n_err), 32'h0);
        hold(P_4, 1);
        chk("rst_req_dv", 32'(digit_valid), 32'h1);
        chk("rst_req_value", 32'(value), 32'h0004);
        chk("rst_req_count", 32'(digit_count), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
